// File: rtl/vec_stream_serializer.sv
// vec_stream_serializer: drains a packed-vector FIFO read port and emits one element per valid/ready beat.
// Ports:
//   clk_in       system clock, posedge
//   rst_in       asynchronous active-low reset
//   chunk_avail  FIFO holds at least one unread chunk
//   rd_en        one-cycle FIFO read strobe
//   rd_data      chunk returned one cycle after rd_en, element 0 in the low bits
//   out_data     current element (0 when out_valid is low)
//   out_valid    out_data valid
//   out_ready    downstream accepts when high with out_valid
//   out_last     final element of a vector
//   vec_done     one-cycle pulse after the last element of a vector is accepted
//   busy         high whenever not idle
module vec_stream_serializer #(
    parameter int VecElements     = 5,
    parameter int ElementsPerRead = 5,
    parameter int NBits           = 8
) (
    input  logic                             clk_in,
    input  logic                             rst_in,
    input  logic                             chunk_avail,
    output logic                             rd_en,
    input  logic [ElementsPerRead*NBits-1:0] rd_data,
    output logic [NBits-1:0]                 out_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             out_last,
    output logic                             vec_done,
    output logic                             busy
);
    localparam int Chunks = VecElements / ElementsPerRead;
    localparam int EW     = ElementsPerRead > 1 ? $clog2(ElementsPerRead) : 1;
    localparam int CW     = Chunks > 1 ? $clog2(Chunks) : 1;
    localparam logic [EW-1:0] ELast = EW'(ElementsPerRead - 1);
    localparam logic [CW-1:0] CLast = CW'(Chunks - 1);

    typedef enum logic [1:0] {IDLE, LOAD, EMIT} state_t;

    state_t                           state;
    logic [ElementsPerRead*NBits-1:0] chunk;
    logic [EW-1:0]                    elem_idx;
    logic [CW-1:0]                    chunk_idx;
    logic                             fire;
    logic                             chunk_end;
    logic                             vec_end;

    assign fire      = out_valid & out_ready;
    assign chunk_end = elem_idx == ELast;
    assign vec_end   = chunk_end && chunk_idx == CLast;
    // Reads are issued only at the two decision points: idle, or the handshake that exhausts a chunk.
    // Gated by reset so no strobe escapes while the block is held.
    assign rd_en     = rst_in && chunk_avail && (state == IDLE || (fire && chunk_end));
    assign out_valid = state == EMIT;
    assign out_data  = out_valid ? chunk[int'(elem_idx)*NBits +: NBits] : '0;
    assign out_last  = out_valid && vec_end;
    assign busy      = state != IDLE;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state     <= IDLE;
            chunk     <= '0;
            elem_idx  <= '0;
            chunk_idx <= '0;
            vec_done  <= 1'b0;
        end else begin
            vec_done <= fire && vec_end;
            case (state)
                IDLE: if (chunk_avail) state <= LOAD;
                LOAD: begin
                    chunk    <= rd_data;
                    elem_idx <= '0;
                    state    <= EMIT;
                end
                EMIT: if (fire) begin
                    elem_idx <= chunk_end ? '0 : elem_idx + 1'b1;
                    if (chunk_end) begin
                        // chunk_idx survives a trip through IDLE so a starved vector resumes in place
                        chunk_idx <= chunk_idx == CLast ? '0 : chunk_idx + 1'b1;
                        state     <= chunk_avail ? LOAD : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
